// File: rtl/dcache_banked_strided.sv
// Banked scratch data cache serving one strided vector access per request.
// Bank conflicts are replayed over extra passes; same-address reads merge into one pass.
module dcache_banked_strided #(
    parameter int unsigned SZ       = 4,
    parameter int unsigned LOGCNT   = 5,
    parameter int unsigned BITS     = 18,
    parameter int unsigned LOGDEPTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [LOGDEPTH+LOGCNT-1:0] req_addr,
    input  logic [LOGDEPTH+LOGCNT-1:0] req_stride,
    input  logic                       req_we,
    input  logic [SZ-1:0]              req_wmask,
    input  logic [BITS*SZ-1:0]         req_wdata,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [BITS*SZ-1:0]         resp_rdata,
    output logic [$clog2(SZ):0]        resp_passes
);
    localparam int unsigned CNT   = 1 << LOGCNT;
    localparam int unsigned DEPTH = 1 << LOGDEPTH;
    localparam int unsigned AW    = LOGDEPTH + LOGCNT;
    localparam int unsigned PW    = $clog2(SZ) + 1;
    localparam int unsigned IW    = (SZ > 1) ? $clog2(SZ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_RESP} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       addr_q, stride_q;
    logic                we_q;
    logic [SZ-1:0]       wmask_q;
    logic [BITS*SZ-1:0]  wdata_q;
    logic [AW-1:0]       a_q [SZ];
    logic [SZ-1:0]       pend_q;
    logic [PW-1:0]       passes_q;
    logic [BITS*SZ-1:0]  rdata_q;
    logic [SZ-1:0]       rd1_q, rd2_q;

    logic [SZ-1:0]       served;
    logic [CNT-1:0]      bank_en;
    logic [LOGDEPTH-1:0] bank_row [CNT];
    logic [BITS-1:0]     bank_wd  [CNT];
    logic [BITS-1:0]     bank_dout [CNT];
    logic [IW-1:0]       w;
    logic                found;
    logic [LOGCNT-1:0]   bk;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_CALC;
            S_CALC:  state_d = (we_q && wmask_q == '0) ? S_RESP : S_ISSUE;
            // one extra ISSUE cycle lets the last pass reach the bank array before DRAIN captures it
            S_ISSUE: if (pend_q == '0) state_d = S_DRAIN;
            S_DRAIN: state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per element: winner is the lowest pending index in the same bank.
    always_comb begin
        served  = '0;
        bank_en = '0;
        w       = '0;
        found   = 1'b0;
        bk      = '0;
        for (int unsigned b = 0; b < CNT; b++) begin
            bank_row[b] = '0;
            bank_wd[b]  = '0;
        end
        if (state_q == S_ISSUE) begin
            for (int unsigned l = 0; l < SZ; l++) begin
                found = 1'b0;
                w     = IW'(l);
                bk    = a_q[l][LOGCNT-1:0];
                for (int unsigned j = 0; j < SZ; j++) begin
                    if (!found && pend_q[j] && a_q[j][LOGCNT-1:0] == bk) begin
                        found = 1'b1;
                        w     = IW'(j);
                    end
                end
                served[l] = pend_q[l] && (we_q ? (w == IW'(l)) : (a_q[w] == a_q[l]));
                if (served[l] && w == IW'(l)) begin
                    bank_en[bk]  = 1'b1;
                    bank_row[bk] = a_q[l][AW-1:LOGCNT];
                    bank_wd[bk]  = wdata_q[BITS*l +: BITS];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            we_q     <= 1'b0;
            wmask_q  <= '0;
            wdata_q  <= '0;
            pend_q   <= '0;
            passes_q <= '0;
            rdata_q  <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            for (int unsigned l = 0; l < SZ; l++) a_q[l] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (req_valid) begin
                    addr_q   <= req_addr;
                    stride_q <= req_stride;
                    we_q     <= req_we;
                    wmask_q  <= req_wmask;
                    wdata_q  <= req_wdata;
                end
                S_CALC: begin
                    for (int unsigned l = 0; l < SZ; l++) a_q[l] <= addr_q + stride_q * AW'(l);
                    pend_q   <= we_q ? wmask_q : '1;
                    passes_q <= '0;
                    rdata_q  <= '0;
                end
                S_ISSUE: if (pend_q != '0) begin
                    pend_q   <= pend_q & ~served;
                    passes_q <= passes_q + PW'(1);
                end
                default: ;
            endcase
            // read-served mask follows the bank pipeline: input regs, then array read
            rd1_q <= we_q ? '0 : served;
            rd2_q <= rd1_q;
            for (int unsigned l = 0; l < SZ; l++) begin
                if (rd2_q[l]) rdata_q[BITS*l +: BITS] <= bank_dout[a_q[l][LOGCNT-1:0]];
            end
        end
    end

    // Bank input registers are part of the BRAM and are not reset, so issued writes complete.
    for (genvar b = 0; b < CNT; b++) begin : g_bank
        logic [BITS-1:0]     mem [DEPTH];
        logic                en_q, we_bq;
        logic [LOGDEPTH-1:0] row_q;
        logic [BITS-1:0]     wd_q, dout_q;

        always_ff @(posedge clk) begin
            en_q  <= bank_en[b];
            we_bq <= we_q;
            row_q <= bank_row[b];
            wd_q  <= bank_wd[b];
            if (en_q) begin
                if (we_bq) mem[row_q] <= wd_q;
                else       dout_q     <= mem[row_q];
            end
        end
        assign bank_dout[b] = dout_q;
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_RESP);
    assign resp_rdata  = rdata_q;
    assign resp_passes = passes_q;

endmodule
